// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions.
// Contents: XLEN, the NOP encoding used for pipeline bubbles, and the
// fetch_entry_t payload {instr, pc} carried by the fetch queues.
package rv_pipe_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t.
// Ports: clk, rst_n (async active-low), push/wdata, pop, clear (drops all
// entries, wins over push/pop), rdata_c (head entry, combinational read),
// count/full/empty (registered occupancy).
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fetch_queue
    import rv_pipe_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata_c,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [CW-1:0] count_nxt;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata_c = mem[rd_ptr];

    // Occupancy after this edge; push+pop together leaves it unchanged.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end and IF/ID register for the 5-stage RV32I pipe.
// Ports: clk, rst_n (async active-low); hazard controls PCWrite, IF_ID_Write,
// IF_ID_Flush; EX redirect redirect_valid/redirect_pc; imem request
// imem_req_valid/imem_req_ready/imem_addr; imem response imem_rsp_valid/
// imem_rsp_data; decode outputs instrD, pcD, pcPlus4D, validD.
// Build option FETCH_QUEUE_BYPASS_EN: when defined, a response arriving with
// the queue empty and IF/ID free is loaded straight into IF/ID.
module fetch_unit
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        IF_ID_Flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcPlus4D,
    output logic        validD
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    // In-flight responses are bounded by memory latency, far below 255.
    localparam int unsigned DW = 8;

    logic [XLEN-1:0] fpc;
    logic [DW-1:0]   drop_cnt;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   qcount;
    logic            pcf_full;
    logic            pcf_empty;
    logic            q_full;
    logic            q_empty;
    fetch_entry_t    pcf_wdata;
    fetch_entry_t    pcf_head;
    fetch_entry_t    q_wdata;
    fetch_entry_t    q_head;
    logic            req_fire_c;
    logic            rsp_drop_c;
    logic            rsp_take_c;
    logic            q_push_c;
    logic            q_pop_c;
    logic            bypass_c;
    logic            kill_c;
    logic            unused_bits;

    // Credit check uses registered counts only; a pop this cycle earns nothing.
    assign imem_req_valid = rst_n && PCWrite && !redirect_valid &&
                            ((SW'(outstanding) + SW'(qcount)) < SW'(QDEPTH));
    assign imem_addr  = fpc;
    assign req_fire_c = imem_req_valid && imem_req_ready;

    assign rsp_drop_c = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_take_c = imem_rsp_valid && (drop_cnt == '0) && !pcf_empty;
    assign kill_c     = IF_ID_Flush || redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_c = rsp_take_c && q_empty && IF_ID_Write && !kill_c;
`else
    assign bypass_c = 1'b0;
`endif

    assign q_push_c = rsp_take_c && !bypass_c;
    assign q_pop_c  = !kill_c && IF_ID_Write && !q_empty;

    assign pcf_wdata = '{instr: '0, pc: fpc};
    assign q_wdata   = '{instr: imem_rsp_data, pc: pcf_head.pc};

    // PCs of requests in flight; its occupancy is the outstanding count.
    fetch_queue #(.DEPTH(QDEPTH)) u_pc_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (req_fire_c),
        .pop     (rsp_take_c),
        .clear   (redirect_valid),
        .wdata   (pcf_wdata),
        .rdata_c (pcf_head),
        .count   (outstanding),
        .full    (pcf_full),
        .empty   (pcf_empty)
    );

    // Returned instructions awaiting decode.
    fetch_queue #(.DEPTH(QDEPTH)) u_instr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (q_push_c),
        .pop     (q_pop_c),
        .clear   (redirect_valid),
        .wdata   (q_wdata),
        .rdata_c (q_head),
        .count   (qcount),
        .full    (q_full),
        .empty   (q_empty)
    );

    assign unused_bits = ^{pcf_head.instr, pcf_full, q_full};

    // Fetch PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc <= RESET_PC;
        end else if (redirect_valid) begin
            fpc <= redirect_pc;
        end else if (req_fire_c) begin
            fpc <= fpc + XLEN'(4);
        end
    end

    // Stale responses to discard; a redirect adds every request still in
    // flight, less one accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= drop_cnt - DW'(rsp_drop_c) + DW'(outstanding) - DW'(rsp_take_c);
        end else if (rsp_drop_c) begin
            drop_cnt <= drop_cnt - DW'(1);
        end
    end

    // IF/ID register: kill, hold, queue head, bypassed response, bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD   <= NOP_INSTR;
            pcD      <= '0;
            pcPlus4D <= XLEN'(4);
            validD   <= 1'b0;
        end else if (kill_c) begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end else if (IF_ID_Write) begin
            if (!q_empty) begin
                instrD   <= q_head.instr;
                pcD      <= q_head.pc;
                pcPlus4D <= q_head.pc + XLEN'(4);
                validD   <= 1'b1;
            end else if (bypass_c) begin
                instrD   <= imem_rsp_data;
                pcD      <= pcf_head.pc;
                pcPlus4D <= pcf_head.pc + XLEN'(4);
                validD   <= 1'b1;
            end else begin
                instrD <= NOP_INSTR;
                validD <= 1'b0;
            end
        end
    end

endmodule
